// File: rtl/azimuth_pkg.sv
// Shared definitions for the azimuth sweep path: sweep geometry, stream width
// and the loader's frame-assembly states.
package azimuth_pkg;

    localparam int SWEEP_SIZE = 3200;
    localparam int AXIS_W     = 32;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        FULL    = 2'd1,
        DISCARD = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that increments on request and sticks at all-ones instead of
// wrapping, so a long-running fault count never reads back as small.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/azimuth_data_loader.sv
// Assembles one sweep bitmap per trigger from a 32-bit AXI4-Stream into a
// shadow register and transfers complete frames to the held DATA bus on TRIG.
module azimuth_data_loader
    import azimuth_pkg::*;
#(
    parameter int SIZE   = SWEEP_SIZE,
    parameter int WORD_W = AXIS_W,
    parameter int CNT_W  = 16
) (
    input  logic              SYS_CLK,
    input  logic              RESETN,
    input  logic              EN,
    input  logic              TRIG,
    input  logic [WORD_W-1:0] S_AXIS_TDATA,
    input  logic              S_AXIS_TVALID,
    input  logic              S_AXIS_TLAST,
    output logic              S_AXIS_TREADY,
    output logic [SIZE-1:0]   DATA,
    output logic              LOADED,
    output logic [CNT_W-1:0]  UNDERRUN_CNT,
    output logic [CNT_W-1:0]  FRAME_ERR_CNT
);

    localparam int NWORDS = SIZE / WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    generate
        if (((SIZE % WORD_W) != 0) || (SIZE < WORD_W)) begin : g_size_check
            $error("azimuth_data_loader: SIZE must be a non-zero multiple of WORD_W");
        end
    endgenerate

    state_e            state_r;
    state_e            state_nxt_s;
    logic [IDX_W-1:0]  widx_r;
    logic [IDX_W-1:0]  widx_nxt_s;
    logic [SIZE-1:0]   shadow_r;
    logic [SIZE-1:0]   data_r;
    logic              loaded_r;
    logic              run_r;
    logic              tready_s;
    logic              accept_s;
    logic              trig_s;
    logic              at_end_s;
    logic              load_s;
    logic              underrun_inc_s;
    logic              frame_err_inc_s;

    // Handshake and trigger qualification; run_r keeps TREADY low through reset.
    always_comb begin
        tready_s       = EN && run_r && (state_r != FULL);
        accept_s       = S_AXIS_TVALID && tready_s;
        trig_s         = EN && TRIG;
        at_end_s       = (widx_r == LAST_IDX);
        load_s         = trig_s && (state_r == FULL);
        underrun_inc_s = trig_s && (state_r != FULL);
    end

    // Frame-assembly state machine and word index.
    always_comb begin
        state_nxt_s     = state_r;
        widx_nxt_s      = widx_r;
        frame_err_inc_s = 1'b0;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    if (at_end_s) begin
                        if (S_AXIS_TLAST) begin
                            state_nxt_s = FULL;
                        end else begin
                            frame_err_inc_s = 1'b1;
                            state_nxt_s     = DISCARD;
                        end
                    end else if (S_AXIS_TLAST) begin
                        // Short frame: drop it and restart at word 0.
                        frame_err_inc_s = 1'b1;
                        widx_nxt_s      = {IDX_W{1'b0}};
                    end else begin
                        widx_nxt_s = widx_r + IDX_W'(1);
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            FULL: begin
                if (load_s) begin
                    state_nxt_s = FILL;
                    widx_nxt_s  = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s = state_r;
                end
            end
            DISCARD: begin
                if (accept_s && S_AXIS_TLAST) begin
                    state_nxt_s = FILL;
                    widx_nxt_s  = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = FILL;
                widx_nxt_s  = {IDX_W{1'b0}};
            end
        endcase
    end

    // State and index registers.
    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_r <= FILL;
            widx_r  <= {IDX_W{1'b0}};
            run_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            widx_r  <= widx_nxt_s;
            run_r   <= 1'b1;
        end
    end

    // Word steering: accepted word k lands at bits [k*WORD_W +: WORD_W].
    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            shadow_r <= {SIZE{1'b0}};
        end else if (accept_s && (state_r == FILL)) begin
            shadow_r[widx_r*WORD_W +: WORD_W] <= S_AXIS_TDATA;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Held sweep bus and its update strobe; DATA moves only on a FULL-state trigger.
    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            data_r   <= {SIZE{1'b0}};
            loaded_r <= 1'b0;
        end else begin
            data_r   <= load_s ? shadow_r : data_r;
            loaded_r <= load_s;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_underrun_cnt (
        .clk   (SYS_CLK),
        .rst_n (RESETN),
        .inc   (underrun_inc_s),
        .count (UNDERRUN_CNT)
    );

    sat_counter #(.CNT_W(CNT_W)) u_frame_err_cnt (
        .clk   (SYS_CLK),
        .rst_n (RESETN),
        .inc   (frame_err_inc_s),
        .count (FRAME_ERR_CNT)
    );

    assign S_AXIS_TREADY = tready_s;
    assign DATA          = data_r;
    assign LOADED        = loaded_r;

endmodule

// File: tb/tb_azimuth_data_loader.sv
// Scenario bench for azimuth_data_loader: expected frames are queued as they are
// streamed and popped when a LOADED pulse appears.
module tb_azimuth_data_loader;

    localparam int SIZE   = 3200;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;
    localparam int NW     = SIZE / WORD_W;

    logic              SYS_CLK = 1'b0;
    logic              RESETN;
    logic              EN;
    logic              TRIG;
    logic [WORD_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;
    logic [SIZE-1:0]   data;
    logic              loaded;
    logic [CNT_W-1:0]  und_cnt;
    logic [CNT_W-1:0]  ferr_cnt;

    int checks   = 0;
    int failures = 0;
    int und_exp  = 0;
    int ferr_exp = 0;
    logic [SIZE-1:0] exp_q[$];
    logic [SIZE-1:0] last_data = '0;
    logic [SIZE-1:0] exp_frame;

    azimuth_data_loader dut (
        .SYS_CLK       (SYS_CLK),
        .RESETN        (RESETN),
        .EN            (EN),
        .TRIG          (TRIG),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TREADY (tready),
        .DATA          (data),
        .LOADED        (loaded),
        .UNDERRUN_CNT  (und_cnt),
        .FRAME_ERR_CNT (ferr_cnt)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    function automatic logic [SIZE-1:0] build_frame(input logic [31:0] base);
        logic [SIZE-1:0] f;
        f = '0;
        for (int k = 0; k < NW; k++) f[k*WORD_W +: WORD_W] = base + 32'(k);
        return f;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic l, input logic t);
        int n;
        @(negedge SYS_CLK);
        tvalid = 1'b1; tdata = d; tlast = l; TRIG = t;
        #1;
        n = 0;
        while (!tready && n < 50) begin
            @(negedge SYS_CLK); #1; n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL send_word_timeout tready=%b required 1", tready);
        end
        @(posedge SYS_CLK); #1;
        tvalid = 1'b0; tlast = 1'b0; TRIG = 1'b0;
    endtask

    task automatic send_range(input logic [31:0] base, input int from, input int to, input logic last_at_end);
        for (int k = from; k <= to; k++) send_word(base + 32'(k), (k == to) && last_at_end, 1'b0);
    endtask

    task automatic trig_pulse();
        @(negedge SYS_CLK);
        TRIG = 1'b1;
        @(posedge SYS_CLK); #1;
        TRIG = 1'b0;
    endtask

    task automatic expect_frame_loaded(input string name);
        checks++;
        if (loaded !== 1'b1) begin
            failures++; $display("FAIL %s_loaded got=%b required 1", name, loaded);
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++; $display("FAIL %s_scoreboard_empty", name);
        end else begin
            exp_frame = exp_q.pop_front();
            if (data !== exp_frame) begin
                failures++;
                $display("FAIL %s_data got lo=%h hi=%h required lo=%h hi=%h", name,
                         data[31:0], data[SIZE-1 -: 32], exp_frame[31:0], exp_frame[SIZE-1 -: 32]);
            end
            last_data = exp_frame;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (data !== '0 || loaded !== 1'b0 || tready !== 1'b0) begin
            failures++; $display("FAIL reset_outputs got data_lo=%h loaded=%b tready=%b required 0", data[31:0], loaded, tready);
        end
        checks++;
        if (und_cnt !== 16'd0 || ferr_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_counters got und=%0d ferr=%0d required 0", und_cnt, ferr_cnt);
        end
        @(negedge SYS_CLK); EN = 1'b1;
        @(negedge SYS_CLK); #1;
        checks++;
        if (tready !== 1'b1) begin
            failures++; $display("FAIL reset_enable_tready got=%b required 1", tready);
        end
    endtask

    task automatic test_basic_frame();
        send_range(32'd0, 0, NW - 1, 1'b1);
        exp_q.push_back(build_frame(32'd0));
        @(negedge SYS_CLK);
        checks++;
        if (tready !== 1'b0 || loaded !== 1'b0) begin
            failures++; $display("FAIL basic_full_wait got tready=%b loaded=%b required 0 0", tready, loaded);
        end
        trig_pulse();
        expect_frame_loaded("basic");
        checks++;
        if (data[31:0] !== 32'd0 || data[63:32] !== 32'd1 || data[3199:3168] !== 32'd99) begin
            failures++; $display("FAIL basic_slices got w0=%0d w1=%0d w99=%0d required 0 1 99", data[31:0], data[63:32], data[3199:3168]);
        end
        @(posedge SYS_CLK); #1;
        checks++;
        if (loaded !== 1'b0 || data !== last_data) begin
            failures++; $display("FAIL basic_pulse_width got loaded=%b required 0", loaded);
        end
    endtask

    task automatic test_underrun();
        send_range(32'd1000, 0, 49, 1'b0);
        trig_pulse();
        und_exp++;
        checks++;
        if (loaded !== 1'b0 || data !== last_data) begin
            failures++; $display("FAIL underrun_hold got loaded=%b data_lo=%h required 0 %h", loaded, data[31:0], last_data[31:0]);
        end
        checks++;
        if (und_cnt !== 16'(und_exp)) begin
            failures++; $display("FAIL underrun_cnt got=%0d required %0d", und_cnt, und_exp);
        end
        send_range(32'd1000, 50, NW - 1, 1'b1);
        exp_q.push_back(build_frame(32'd1000));
        trig_pulse();
        expect_frame_loaded("underrun_resume");
    endtask

    task automatic test_short_frame();
        send_range(32'd500, 0, 40, 1'b1);
        ferr_exp++;
        checks++;
        if (ferr_cnt !== 16'(ferr_exp) || data !== last_data) begin
            failures++; $display("FAIL short_frame_err got=%0d required %0d", ferr_cnt, ferr_exp);
        end
        send_range(32'd2000, 0, NW - 1, 1'b1);
        exp_q.push_back(build_frame(32'd2000));
        trig_pulse();
        expect_frame_loaded("short_recover");
    endtask

    task automatic test_long_frame();
        send_range(32'd3000, 0, NW - 1, 1'b0);
        ferr_exp++;
        checks++;
        if (ferr_cnt !== 16'(ferr_exp)) begin
            failures++; $display("FAIL long_frame_err got=%0d required %0d", ferr_cnt, ferr_exp);
        end
        send_range(32'd4000, 0, 4, 1'b1);
        checks++;
        if (ferr_cnt !== 16'(ferr_exp) || data !== last_data || tready !== 1'b1) begin
            failures++; $display("FAIL long_discard got ferr=%0d tready=%b required %0d 1", ferr_cnt, tready, ferr_exp);
        end
        send_range(32'd5000, 0, NW - 1, 1'b1);
        exp_q.push_back(build_frame(32'd5000));
        trig_pulse();
        expect_frame_loaded("long_recover");
    endtask

    task automatic test_coincident_trig();
        send_range(32'd6000, 0, NW - 2, 1'b0);
        send_word(32'd6000 + 32'(NW - 1), 1'b1, 1'b1);
        exp_q.push_back(build_frame(32'd6000));
        und_exp++;
        checks++;
        if (loaded !== 1'b0 || tready !== 1'b0 || data !== last_data) begin
            failures++; $display("FAIL coincident_noload got loaded=%b tready=%b required 0 0", loaded, tready);
        end
        checks++;
        if (und_cnt !== 16'(und_exp)) begin
            failures++; $display("FAIL coincident_underrun got=%0d required %0d", und_cnt, und_exp);
        end
        trig_pulse();
        expect_frame_loaded("coincident_next");
    endtask

    task automatic test_enable_pause();
        send_range(32'd7000, 0, 30, 1'b0);
        @(negedge SYS_CLK); EN = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge SYS_CLK);
            tvalid = 1'b1; tdata = 32'hDEAD_0000 + 32'(i); TRIG = (i == 10);
            #1;
            if (i == 5) begin
                checks++;
                if (tready !== 1'b0) begin
                    failures++; $display("FAIL enable_tready got=%b required 0", tready);
                end
            end
        end
        @(negedge SYS_CLK);
        tvalid = 1'b0; TRIG = 1'b0;
        checks++;
        if (und_cnt !== 16'(und_exp) || ferr_cnt !== 16'(ferr_exp) || data !== last_data || loaded !== 1'b0) begin
            failures++; $display("FAIL enable_hold got und=%0d ferr=%0d loaded=%b required %0d %0d 0", und_cnt, ferr_cnt, loaded, und_exp, ferr_exp);
        end
        EN = 1'b1;
        send_range(32'd7000, 31, NW - 1, 1'b1);
        exp_q.push_back(build_frame(32'd7000));
        trig_pulse();
        expect_frame_loaded("enable_resume");
    endtask

    task automatic test_reset_mid_frame();
        send_range(32'd8000, 0, 29, 1'b0);
        #2 RESETN = 1'b0;
        #1;
        checks++;
        if (data !== '0 || loaded !== 1'b0 || tready !== 1'b0 || und_cnt !== 16'd0 || ferr_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_async got data_lo=%h tready=%b und=%0d ferr=%0d required 0", data[31:0], tready, und_cnt, ferr_cnt);
        end
        und_exp = 0; ferr_exp = 0; last_data = '0; exp_q.delete();
        repeat (2) @(negedge SYS_CLK);
        RESETN = 1'b1;
        send_range(32'd9000, 0, NW - 1, 1'b1);
        exp_q.push_back(build_frame(32'd9000));
        trig_pulse();
        expect_frame_loaded("reset_recover");
        checks++;
        if (und_cnt !== 16'd0 || ferr_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_recover_counters got und=%0d ferr=%0d required 0 0", und_cnt, ferr_cnt);
        end
    endtask

    initial begin
        RESETN = 1'b0; EN = 1'b0; TRIG = 1'b0;
        tdata = '0; tvalid = 1'b0; tlast = 1'b0;
        repeat (3) @(negedge SYS_CLK);
        RESETN = 1'b1;
        @(negedge SYS_CLK); #1;
        test_reset();
        test_basic_frame();
        test_underrun();
        test_short_frame();
        test_long_frame();
        test_coincident_trig();
        test_enable_pause();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
